labmininios_imem_loader: RTL and testbench

LABMININIOS_IMEM_LOADER -- requirements
Module: labmininios_imem_loader

---
 rtl/labmininios_imem_loader_if.sv | 35 +++
 rtl/labmininios_imem_loader.sv | 201 ++++++++++++++++++++
 tb/tb_labmininios_imem_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/labmininios_imem_loader_if.sv
// Bundle of control, byte-stream and Avalon-MM signals for the instruction-memory loader.
// The loader sits on the slave modport; whatever drives it (host logic, bench) uses master.
interface labmininios_imem_loader_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [31:0]       checksum;

    modport master (
        output start, abort, base_addr, word_count, s_data, s_valid, readdata,
        input  s_ready, address, byteenable, chipselect, write, writedata,
        input  busy, done, error, checksum
    );

    modport slave (
        input  start, abort, base_addr, word_count, s_data, s_valid, readdata,
        output s_ready, address, byteenable, chipselect, write, writedata,
        output busy, done, error, checksum
    );
endinterface

// File: rtl/labmininios_imem_loader.sv
// Loads a little-endian byte stream into word memory over Avalon-MM, then reads the
// region back and compares the readback sum against the write checksum.
module labmininios_imem_loader #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 51200
) (
    input logic                     clk,
    input logic                     reset_n,
    labmininios_imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
        StVerify,
        StDrain,
        StFinish
    } state_e;

    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [ADDR_W-1:0] ridx_q, ridx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       csum_q, csum_d;
    logic [31:0]       rsum_q, rsum_d;
    logic              rd_pend_q, rd_pend_d;
    logic              error_q, error_d;

    logic              range_err;
    logic              byte_acc;
    logic              abort_act;
    logic              last_word;
    logic              last_read;
    logic [31:0]       rsum_acc;

    // Overflow-safe range check: one extra bit so base+count cannot wrap.
    assign range_err = ({1'b0, bus.base_addr} + {1'b0, bus.word_count}) > DepthW;
    assign byte_acc  = (state_q == StCollect) && bus.s_valid;
    assign abort_act = bus.abort && (state_q != StIdle) && (state_q != StFinish);
    assign last_word = (widx_q == count_q - ADDR_W'(1));
    assign last_read = (ridx_q == count_q - ADDR_W'(1));
    assign rsum_acc  = rd_pend_q ? (rsum_q + bus.readdata) : rsum_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.word_count == '0 || range_err) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (byte_acc && byte_idx_q == 2'd3) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                state_d = last_word ? StVerify : StCollect;
            end
            StVerify: begin
                if (last_read) begin
                    state_d = StDrain;
                end
            end
            StDrain:  state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (abort_act) begin
            state_d = StFinish;
        end
    end

    // Output logic
    always_comb begin
        bus.s_ready    = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.byteenable = 4'h0;
        bus.address    = '0;
        bus.busy       = (state_q != StIdle);
        bus.done       = (state_q == StFinish);
        unique case (state_q)
            StCollect: bus.s_ready = 1'b1;
            StWrite: begin
                bus.chipselect = 1'b1;
                bus.write      = 1'b1;
                bus.byteenable = 4'hF;
                bus.address    = base_q + widx_q;
            end
            StVerify: begin
                bus.chipselect = 1'b1;
                bus.byteenable = 4'hF;
                bus.address    = base_q + ridx_q;
            end
            default: ;
        endcase
    end

    assign bus.writedata = wdata_q;
    assign bus.checksum  = csum_q;
    assign bus.error     = error_q;

    // Datapath next-state
    always_comb begin
        base_d     = base_q;
        count_d    = count_q;
        widx_d     = widx_q;
        ridx_d     = ridx_q;
        byte_idx_d = byte_idx_q;
        wdata_d    = wdata_q;
        csum_d     = csum_q;
        rsum_d     = rsum_acc;
        rd_pend_d  = (state_q == StVerify);
        error_d    = error_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    base_d     = bus.base_addr;
                    count_d    = bus.word_count;
                    widx_d     = '0;
                    ridx_d     = '0;
                    byte_idx_d = '0;
                    csum_d     = '0;
                    rsum_d     = '0;
                    error_d    = (bus.word_count != '0) && range_err;
                end
            end
            StCollect: begin
                if (byte_acc) begin
                    wdata_d[{byte_idx_q, 3'b000} +: 8] = bus.s_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end
            StWrite: begin
                csum_d = csum_q + wdata_q;
                widx_d = widx_q + ADDR_W'(1);
                ridx_d = '0;
            end
            StVerify: begin
                ridx_d = ridx_q + ADDR_W'(1);
            end
            StDrain: begin
                // The last readback lands this cycle, so compare the updated sum.
                error_d = error_q | (rsum_acc != csum_q);
            end
            default: ;
        endcase
        if (abort_act) begin
            error_d    = 1'b1;
            byte_idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q     <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            ridx_q     <= '0;
            byte_idx_q <= '0;
            wdata_q    <= '0;
            csum_q     <= '0;
            rsum_q     <= '0;
            rd_pend_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            base_q     <= base_d;
            count_q    <= count_d;
            widx_q     <= widx_d;
            ridx_q     <= ridx_d;
            byte_idx_q <= byte_idx_d;
            wdata_q    <= wdata_d;
            csum_q     <= csum_d;
            rsum_q     <= rsum_d;
            rd_pend_q  <= rd_pend_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_labmininios_imem_loader.sv
// Bench for labmininios_imem_loader: a per-cycle expected timeline is built from each job's
// parameters, replayed as stimulus and compared against the DUT on every falling edge.
module tb_labmininios_imem_loader;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 51200;

    typedef struct packed {
        logic              start;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] cnt;
        logic              valid;
        logic [7:0]        data;
        logic              abort;
        logic              arm;
        logic              ready;
        logic              cs;
        logic              we;
        logic              busy;
        logic              done;
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [31:0]       csum;
        logic              chk_wdata;
    } cyc_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    labmininios_imem_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

    labmininios_imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    cyc_t        sched[$];
    cyc_t        cur;
    bit          chk_en = 1'b0;
    logic        prev_err  = 1'b0;
    logic [31:0] prev_csum = '0;

    logic [31:0]       mem [logic [ADDR_W-1:0]];
    logic [47:0]       wr_log[$];
    logic [ADDR_W-1:0] rd_log[$];
    logic [31:0]       rd_hold = '0;
    int                corrupt_req  = 0;
    int                corrupt_done = 0;
    int                done_cnt  = 0;
    logic              done_err  = 1'b0;
    logic [31:0]       done_csum = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: services the bus at mid-cycle, readback appears one edge later.
    always @(negedge clk) begin
        rd_hold = $urandom;
        if (reset_n && bus_if.chipselect === 1'b1) begin
            if (bus_if.write === 1'b1) begin
                mem[bus_if.address] = bus_if.writedata;
                wr_log.push_back({bus_if.address, bus_if.writedata});
            end else begin
                rd_hold = mem.exists(bus_if.address) ? mem[bus_if.address] : 32'h0;
                if (corrupt_done < corrupt_req) begin
                    rd_hold = rd_hold ^ (32'h1 << $urandom_range(0, 31));
                    corrupt_done++;
                end
                rd_log.push_back(bus_if.address);
            end
        end
    end

    always @(posedge clk) bus_if.readdata <= rd_hold;

    always @(negedge clk) begin
        if (reset_n && bus_if.done === 1'b1) begin
            done_cnt++;
            done_err  = bus_if.error;
            done_csum = bus_if.checksum;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(bus_if.busy), 64'(cur.busy));
            check("s_ready", 64'(bus_if.s_ready), 64'(cur.ready));
            check("done", 64'(bus_if.done), 64'(cur.done));
            check("error", 64'(bus_if.error), 64'(cur.err));
            check("checksum", 64'(bus_if.checksum), 64'(cur.csum));
            check("chipselect", 64'(bus_if.chipselect), 64'(cur.cs));
            check("write", 64'(bus_if.write), 64'(cur.we));
            if (cur.cs) begin
                check("address", 64'(bus_if.address), 64'(cur.addr));
                check("byteenable", 64'(bus_if.byteenable), 64'hF);
            end
            if (cur.chk_wdata) check("writedata", 64'(bus_if.writedata), 64'(cur.wdata));
        end
    end

    function automatic cyc_t idle_rec();
        cyc_t r;
        r       = '0;
        r.err   = prev_err;
        r.csum  = prev_csum;
        r.valid = 1'($urandom);
        r.data  = 8'($urandom);
        r.abort = ($urandom_range(0, 3) == 0);
        return r;
    endfunction

    // Non-idle cycle: stray start and stream noise must be ignored by the DUT.
    function automatic cyc_t busy_rec(input logic [31:0] sum);
        cyc_t r;
        r       = '0;
        r.busy  = 1'b1;
        r.csum  = sum;
        r.start = ($urandom_range(0, 7) == 0);
        r.base  = ADDR_W'($urandom);
        r.cnt   = ADDR_W'($urandom);
        r.valid = 1'($urandom);
        r.data  = 8'($urandom);
        return r;
    endfunction

    task automatic build_job(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] cnt,
                             input logic [31:0] words[$], input int abort_idx,
                             input bit corrupt, input bit gaps);
        cyc_t        job[$];
        cyc_t        r;
        logic [31:0] sum;
        logic [31:0] fsum;
        bit          bad;
        int          idx;
        r       = idle_rec();
        r.start = 1'b1;
        r.base  = base;
        r.cnt   = cnt;
        r.arm   = corrupt;
        job.push_back(r);
        bad = (cnt != 0) && (({1'b0, base} + {1'b0, cnt}) > (ADDR_W + 1)'(DEPTH));
        sum = '0;
        if (cnt == 0 || bad) begin
            r      = busy_rec(sum);
            r.done = 1'b1;
            r.err  = bad;
            job.push_back(r);
        end else begin
            for (int w = 0; w < int'(cnt); w++) begin
                for (int b = 0; b < 4; b++) begin
                    repeat (gaps ? $urandom_range(0, 2) : 0) begin
                        r       = busy_rec(sum);
                        r.ready = 1'b1;
                        r.valid = 1'b0;
                        job.push_back(r);
                    end
                    r       = busy_rec(sum);
                    r.ready = 1'b1;
                    r.valid = 1'b1;
                    r.data  = words[w][8*b +: 8];
                    job.push_back(r);
                end
                r           = busy_rec(sum);
                r.cs        = 1'b1;
                r.we        = 1'b1;
                r.addr      = base + ADDR_W'(w);
                r.wdata     = words[w];
                r.chk_wdata = 1'b1;
                job.push_back(r);
                sum += words[w];
            end
            for (int k = 0; k < int'(cnt); k++) begin
                r      = busy_rec(sum);
                r.cs   = 1'b1;
                r.addr = base + ADDR_W'(k);
                job.push_back(r);
            end
            job.push_back(busy_rec(sum));
            r      = busy_rec(sum);
            r.done = 1'b1;
            r.err  = corrupt;
            job.push_back(r);
        end
        if (abort_idx > 0 && job.size() > 2) begin
            idx = 1 + (abort_idx - 1) % (job.size() - 2);
            job[idx].abort = 1'b1;
            fsum = job[idx].csum + (job[idx].we ? job[idx].wdata : 32'h0);
            while (job.size() > idx + 1) void'(job.pop_back());
            r      = busy_rec(fsum);
            r.done = 1'b1;
            r.err  = 1'b1;
            job.push_back(r);
        end
        prev_err  = job[job.size()-1].err;
        prev_csum = job[job.size()-1].csum;
        foreach (job[i]) sched.push_back(job[i]);
        repeat ($urandom_range(0, 2)) sched.push_back(idle_rec());
    endtask

    // Replays the schedule from just after a rising edge; stop_at leaves records unplayed.
    task automatic run_sched(input int stop_at);
        int i;
        i = 0;
        while (sched.size() > 0) begin
            if (stop_at >= 0 && i == stop_at) begin
                chk_en = 1'b0;
                return;
            end
            cur = sched.pop_front();
            bus_if.start      = cur.start;
            bus_if.abort      = cur.abort;
            bus_if.base_addr  = cur.base;
            bus_if.word_count = cur.cnt;
            bus_if.s_valid    = cur.valid;
            bus_if.s_data     = cur.data;
            if (cur.arm) corrupt_req++;
            chk_en = 1'b1;
            @(posedge clk);
            #1;
            i++;
        end
        chk_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 64'(bus_if.s_ready), 64'h0);
        check({tag, "_chipselect"}, 64'(bus_if.chipselect), 64'h0);
        check({tag, "_write"}, 64'(bus_if.write), 64'h0);
        check({tag, "_busy"}, 64'(bus_if.busy), 64'h0);
        check({tag, "_done"}, 64'(bus_if.done), 64'h0);
        check({tag, "_error"}, 64'(bus_if.error), 64'h0);
        check({tag, "_checksum"}, 64'(bus_if.checksum), 64'h0);
        check({tag, "_address"}, 64'(bus_if.address), 64'h0);
        check({tag, "_writedata"}, 64'(bus_if.writedata), 64'h0);
        check({tag, "_byteenable"}, 64'(bus_if.byteenable), 64'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words[$];
        int wr0, rd0, dn0;
        int kind;
        logic [ADDR_W-1:0] base, cnt;
        bus_if.start = 0; bus_if.abort = 0; bus_if.base_addr = '0; bus_if.word_count = '0;
        bus_if.s_valid = 0; bus_if.s_data = '0;
        #1 reset_n = 1'b0;
        #2 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: two words, known bytes
        words = '{32'h44332211, 32'h88776655};
        wr0 = wr_log.size(); rd0 = rd_log.size(); dn0 = done_cnt;
        build_job(16'h0010, 16'd2, words, 0, 1'b0, 1'b1);
        check("t1_model_csum", 64'(prev_csum), 64'hCCAA8866);
        run_sched(-1);
        check("t1_nwr", 64'(wr_log.size() - wr0), 64'd2);
        check("t1_wr0", 64'(wr_log[wr0]), {16'h0, 16'h0010, 32'h44332211});
        check("t1_wr1", 64'(wr_log[wr0+1]), {16'h0, 16'h0011, 32'h88776655});
        check("t1_rd0", 64'(rd_log[rd0]), 64'h0010);
        check("t1_rd1", 64'(rd_log[rd0+1]), 64'h0011);
        check("t1_done", 64'(done_cnt - dn0), 64'd1);
        check("t1_err", 64'(done_err), 64'h0);
        check("t1_csum", 64'(done_csum), 64'hCCAA8866);

        // Test 2: zero-length load
        words.delete();
        wr0 = wr_log.size(); rd0 = rd_log.size(); dn0 = done_cnt;
        build_job(16'h0020, 16'd0, words, 0, 1'b0, 1'b0);
        run_sched(-1);
        check("t2_bus", 64'(wr_log.size() - wr0 + rd_log.size() - rd0), 64'd0);
        check("t2_done", 64'(done_cnt - dn0), 64'd1);
        check("t2_err", 64'(done_err), 64'h0);

        // Test 3: out of range by one word
        words = '{32'h1, 32'h2};
        wr0 = wr_log.size(); rd0 = rd_log.size(); dn0 = done_cnt;
        build_job(16'd51199, 16'd2, words, 0, 1'b0, 1'b0);
        run_sched(-1);
        check("t3_bus", 64'(wr_log.size() - wr0 + rd_log.size() - rd0), 64'd0);
        check("t3_done", 64'(done_cnt - dn0), 64'd1);
        check("t3_err", 64'(done_err), 64'h1);

        // Exact top-of-memory fit is legal
        dn0 = done_cnt;
        build_job(16'd51198, 16'd2, words, 0, 1'b0, 1'b1);
        run_sched(-1);
        check("edge_err", 64'(done_err), 64'h0);
        check("edge_done", 64'(done_cnt - dn0), 64'd1);

        // Test 4: corrupted readback
        words = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        build_job(16'h0200, 16'd3, words, 0, 1'b1, 1'b1);
        run_sched(-1);
        check("t4_err", 64'(done_err), 64'h1);

        // Test 5: abort after six bytes of a three-word load, then a normal load
        wr0 = wr_log.size();
        build_job(16'h0300, 16'd3, words, 8, 1'b0, 1'b0);
        check("t5_model_csum", 64'(prev_csum), 64'hDEADBEEF);
        run_sched(-1);
        check("t5_nwr", 64'(wr_log.size() - wr0), 64'd1);
        check("t5_err", 64'(done_err), 64'h1);
        words = '{32'h00000005, 32'h00000007};
        build_job(16'h0300, 16'd2, words, 0, 1'b0, 1'b1);
        run_sched(-1);
        check("t5_next_err", 64'(done_err), 64'h0);
        check("t5_next_csum", 64'(done_csum), 64'h0000000C);

        // Test 6: reset during verify
        words = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F};
        dn0 = done_cnt;
        build_job(16'h0100, 16'd3, words, 0, 1'b0, 1'b0);
        run_sched(17);
        sched.delete();
        #2 reset_n = 1'b0;
        #1 check_all_zero("t6");
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        prev_err = 1'b0;
        prev_csum = '0;
        @(posedge clk);
        #1;
        repeat (5) sched.push_back(idle_rec());
        run_sched(-1);
        check("t6_nodone", 64'(done_cnt - dn0), 64'd0);

        // Randomized jobs
        for (int j = 0; j < 40; j++) begin
            kind = $urandom_range(0, 9);
            cnt  = ADDR_W'($urandom_range(1, 4));
            words.delete();
            for (int k = 0; k < 4; k++) words.push_back($urandom);
            base = ADDR_W'($urandom_range(0, DEPTH - cnt));
            case (kind)
                0: build_job(ADDR_W'($urandom), '0, words, 0, 1'b0, 1'b1);
                1: build_job(ADDR_W'(DEPTH - cnt + $urandom_range(1, 300)), cnt, words, 0,
                             1'b0, 1'b1);
                2: build_job(base, cnt, words, 0, 1'b1, 1'b1);
                3, 4: build_job(base, cnt, words, $urandom_range(1, 40), 1'b0, 1'b1);
                5: build_job(ADDR_W'(DEPTH - cnt), cnt, words, 0, 1'b0, 1'b1);
                default: build_job(base, cnt, words, 0, 1'b0, 1'b1);
            endcase
            run_sched(-1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
